// File: rtl/mem_line_pkg.sv
// Shared types and sizing helpers for the line-granular memory responder.
package mem_line_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STAT_W  = 32;
    localparam int unsigned ABORT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GNT
    } mem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

    // Number of 32-bit words in one line.
    function automatic int unsigned line_size(input int unsigned line_addr_len);
        return 32'(1) << line_addr_len;
    endfunction

    // Latency counter width, sized for the longer of the two latencies.
    function automatic int unsigned lat_cnt_w(input int unsigned rd_lat, input int unsigned wr_lat);
        return 32'($clog2(rd_lat > wr_lat ? rd_lat : wr_lat)) + 32'd1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Line-wide storage: synchronous write, registered read port.
// The array is not reset; only the read register returns to zero.
module line_ram
    import mem_line_pkg::*;
#(
    parameter int unsigned ADDR_LEN  = 10,
    parameter int unsigned LINE_SIZE = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we_i,
    input  logic                             re_i,
    input  logic [ADDR_LEN-1:0]              addr_i,
    input  logic [LINE_SIZE-1:0][WORD_W-1:0] wdata_i,
    output logic [LINE_SIZE-1:0][WORD_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_LEN;

    logic [LINE_SIZE-1:0][WORD_W-1:0] mem_q [DEPTH];
    logic [LINE_SIZE-1:0][WORD_W-1:0] rdata_q;

    // Line write on commit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds until the next read commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Slow line memory responder: accepts one line read/write, waits the
// programmed latency, commits and pulses gnt; keeps request statistics.
module line_mem_responder
    import mem_line_pkg::*;
#(
    parameter  int unsigned LINE_ADDR_LEN = 3,
    parameter  int unsigned ADDR_LEN      = 10,
    parameter  int unsigned RD_LATENCY    = 4,
    parameter  int unsigned WR_LATENCY    = 4,
    localparam int unsigned LINE_SIZE     = line_size(LINE_ADDR_LEN)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_LEN-1:0]              addr,
    input  logic                             rd_req,
    output logic [LINE_SIZE-1:0][WORD_W-1:0] rd_line,
    input  logic                             wr_req,
    input  logic [LINE_SIZE-1:0][WORD_W-1:0] wr_line,
    output logic                             gnt,
    output logic [STAT_W-1:0]                rd_cnt,
    output logic [STAT_W-1:0]                wr_cnt,
    output logic [ABORT_W-1:0]               abort_cnt
);

    localparam int unsigned     CNT_W   = lat_cnt_w(RD_LATENCY, WR_LATENCY);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    mem_state_t                       state_q, state_d;
    mem_op_t                          op_q, op_d;
    logic [ADDR_LEN-1:0]              addr_q, addr_d;
    logic [LINE_SIZE-1:0][WORD_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             gnt_q, gnt_d;
    logic [STAT_W-1:0]                rd_cnt_q, rd_cnt_d;
    logic [STAT_W-1:0]                wr_cnt_q, wr_cnt_d;
    logic [ABORT_W-1:0]               abort_cnt_q, abort_cnt_d;

    logic                             commit;
    mem_op_t                          commit_op;
    logic [ADDR_LEN-1:0]              commit_addr;
    logic [LINE_SIZE-1:0][WORD_W-1:0] commit_data;
    logic [CNT_W-1:0]                 load;
    logic                             req_held;

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Next state: the counter holds the BUSY cycles left before gnt, so the
    // commit edge is the one that enters GNT and gnt/rd_line appear together.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        abort_cnt_d = abort_cnt_q;
        commit      = 1'b0;
        commit_op   = op_q;
        commit_addr = addr_q;
        commit_data = wdata_q;
        load        = RD_LOAD;
        req_held    = (op_q == OP_WR) ? wr_req : rd_req;

        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    op_d    = wr_req ? OP_WR : OP_RD;
                    addr_d  = addr;
                    wdata_d = wr_line;
                    load    = wr_req ? WR_LOAD : RD_LOAD;
                    if (load == '0) begin
                        commit      = 1'b1;
                        commit_op   = op_d;
                        commit_addr = addr;
                        commit_data = wr_line;
                        cnt_d       = '0;
                        state_d     = GNT;
                    end else begin
                        cnt_d   = load;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req_held) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (abort_cnt_q != '1) begin
                        abort_cnt_d = abort_cnt_q + ABORT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = GNT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GNT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            gnt_d = 1'b1;
            if (commit_op == OP_WR) begin
                wr_cnt_d = wr_cnt_q + STAT_W'(1);
            end else begin
                rd_cnt_d = rd_cnt_q + STAT_W'(1);
            end
        end
    end

    line_ram #(
        .ADDR_LEN  (ADDR_LEN),
        .LINE_SIZE (LINE_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (commit && (commit_op == OP_WR)),
        .re_i    (commit && (commit_op == OP_RD)),
        .addr_i  (commit_addr),
        .wdata_i (commit_data),
        .rdata_o (rd_line)
    );

    assign gnt       = gnt_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed and randomized checks of line_mem_responder against a line-level
// memory model (array of lines, expected read register and counters).
module tb_line_mem_responder;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;

    typedef logic [7:0][31:0] line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic        rd_req;
    logic        wr_req;
    line_t       rd_line;
    line_t       wr_line;
    logic        gnt;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [15:0] abort_cnt;

    line_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .rd_req    (rd_req),
        .rd_line   (rd_line),
        .wr_req    (wr_req),
        .wr_line   (wr_line),
        .gnt       (gnt),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .abort_cnt (abort_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    line_t       mem_m [1024];
    line_t       exp_rd;
    logic [31:0] exp_rdc;
    logic [31:0] exp_wrc;
    logic [15:0] exp_ab;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic line_t rnd_line();
        line_t r;
        for (int i = 0; i < 8; i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until gnt is seen; optionally disturb addr/wr_line meanwhile.
    task automatic wait_gnt(input bit scramble, output int waited, output int gcyc);
        waited = 0;
        gcyc   = -1;
        while (waited < 50) begin
            step();
            waited++;
            if (gnt === 1'b1) begin
                gcyc = cyc;
                break;
            end
            if (scramble) begin
                addr    = 10'($urandom);
                wr_line = rnd_line();
            end
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".rd_line"}, rd_line, exp_rd);
        chk({tag, ".rd_cnt"}, rd_cnt, exp_rdc);
        chk({tag, ".wr_cnt"}, wr_cnt, exp_wrc);
        chk({tag, ".abort_cnt"}, abort_cnt, exp_ab);
    endtask

    // One complete transaction started in the current cycle; returns in the
    // cycle after gnt, when the responder is idle again.
    task automatic do_op(input bit is_wr, input logic [9:0] a, input line_t d,
                         input string tag, output int gcyc);
        int waited;
        addr    = a;
        wr_line = d;
        wr_req  = is_wr;
        rd_req  = !is_wr;
        wait_gnt(1'b1, waited, gcyc);
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk({tag, ".latency"}, 256'(waited), 256'(is_wr ? WR_LAT : RD_LAT));
        if (is_wr) begin
            mem_m[a] = d;
            exp_wrc++;
        end else begin
            exp_rd = mem_m[a];
            exp_rdc++;
        end
        chk_stats(tag);
        step();
        chk({tag, ".gnt_one_cycle"}, 256'(gnt), 256'(0));
    endtask

    initial begin
        line_t d;
        int    g1, g2, waited;

        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        exp_rd  = '0;
        exp_rdc = '0;
        exp_wrc = '0;
        exp_ab  = '0;

        rst     = 1'b0;
        addr    = '0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        wr_line = '0;
        step();
        step();
        chk("reset.gnt", 256'(gnt), 256'(0));
        chk_stats("reset");
        rst = 1'b1;
        step();

        // Read of untouched line after reset
        do_op(1'b0, 10'h005, '0, "rd005", g1);

        // Write then read back the top line
        for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(i);
        do_op(1'b1, 10'h3FF, d, "wr3ff", g1);
        do_op(1'b0, 10'h3FF, '0, "rd3ff", g1);

        // Swap-out then swap-in with no bubble
        do_op(1'b1, 10'h010, rnd_line(), "swap_wr", g1);
        do_op(1'b0, 10'h020, '0, "swap_rd", g2);
        chk("swap.gnt_spacing", 256'(g2 - g1), 256'(WR_LAT + 1));
        do_op(1'b0, 10'h010, '0, "swap_rd010", g1);

        // Abort: read dropped two cycles after accept
        addr   = 10'h3FF;
        rd_req = 1'b1;
        step();
        step();
        rd_req = 1'b0;
        chk("abort.gnt_busy", 256'(gnt), 256'(0));
        step();
        exp_ab++;
        chk("abort.gnt_after", 256'(gnt), 256'(0));
        chk_stats("abort");
        do_op(1'b0, 10'h010, '0, "after_abort", g1);

        // Both requests: write first, read held and served next
        d       = rnd_line();
        addr    = 10'h0AB;
        wr_line = d;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wait_gnt(1'b1, waited, g1);
        wr_req = 1'b0;
        addr   = 10'h0AB;
        chk("prio.wr_latency", 256'(waited), 256'(WR_LAT));
        mem_m[10'h0AB] = d;
        exp_wrc++;
        chk_stats("prio.wr");
        wait_gnt(1'b0, waited, g2);
        rd_req = 1'b0;
        chk("prio.rd_latency", 256'(waited), 256'(RD_LAT + 1));
        exp_rd = mem_m[10'h0AB];
        exp_rdc++;
        chk_stats("prio.rd");
        step();

        // Asynchronous reset in the middle of a write
        addr    = 10'h001;
        wr_line = rnd_line();
        wr_req  = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        exp_rd  = '0;
        exp_rdc = '0;
        exp_wrc = '0;
        exp_ab  = '0;
        chk("arst.gnt", 256'(gnt), 256'(0));
        chk_stats("arst");
        wr_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        do_op(1'b0, 10'h001, '0, "arst_rd001", g1);

        // Randomized traffic over a small set of lines
        for (int n = 0; n < 40; n++) begin
            logic [9:0] a;
            bit         w;
            a = 10'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a = a | 10'h3F8;
            w = ($urandom_range(0, 1) == 1);
            do_op(w, a, rnd_line(), w ? "rnd_wr" : "rnd_rd", g1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
